dmem_port_arbiter: RTL and testbench

Arbitrates one single-ported, synchronous-read data memory between two requesters:
- the CPU pipeline's MEM stage;
- a debug/loader port used for program load and memory inspection.

The block sits between the pipelined CPU core and the data memory. It drives the memory's enable, write, address, data and DMType inputs. It returns a stall to the CPU pipeline whenever the MEM-stage access cannot complete in the current cycle. A starvation counter guarantees forward progress for the debug port.

---
 rtl/dmem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one single-ported, synchronous-read data memory between the CPU
//   MEM stage and a debug/loader port.
//
//   Optional build macro: DMEM_ARB_RR_EN
//     defined   -> round-robin between the two requesters on contention
//     undefined -> fixed CPU priority with a debug starvation override
//
//   Ports
//     clk, rst                    clock, asynchronous active-low reset
//     cpu_req/we/addr/wdata/dmtype MEM-stage access request
//     cpu_rdata, cpu_stall        load data, pipeline freeze
//     dbg_req/we/addr/wdata       debug request, held until dbg_gnt
//     dbg_gnt, dbg_rvalid, dbg_rdata  debug accept pulse, read return
//     mem_en/w/addr/wdata/dmtype  memory command
//     mem_rdata                   memory read data (one cycle after issue)
`timescale 1ns/1ps
module dmem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [2:0]    cpu_dmtype,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_w,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_dmtype,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          dbg_win;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

`ifdef DMEM_ARB_RR_EN
    // Set when the debug port should win the next contended IDLE cycle.
    logic prefer_dbg;

    always_comb dbg_win = dbg_req && (!cpu_req || prefer_dbg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prefer_dbg <= 1'b0;
        else if (state == IDLE && cpu_req && dbg_req)
            prefer_dbg <= !dbg_win;
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starve_cnt;

    always_comb dbg_win = dbg_req && (!cpu_req || starve_cnt == STARVE_LIM);

    // Counts every cycle the debug port waits, including data-phase cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (dbg_gnt)
            starve_cnt <= '0;
        else if (dbg_req && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Debug read data is registered at the end of the data phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= (state == DBG_RD);
            if (state == DBG_RD)
                rdata_q <= mem_rdata;
        end
    end

    // Combinational outputs are gated by rst so every output reads 0 in reset.
    always_comb begin
        state_nxt  = state;
        cpu_rdata  = '0;
        cpu_stall  = 1'b0;
        dbg_gnt    = 1'b0;
        dbg_rvalid = rvalid_q;
        dbg_rdata  = rdata_q;
        mem_en     = 1'b0;
        mem_w      = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_dmtype = 3'b000;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (dbg_win) begin
                        dbg_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_w     = dbg_we;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                        cpu_stall = cpu_req;
                        if (!dbg_we)
                            state_nxt = DBG_RD;
                    end else if (cpu_req) begin
                        mem_en     = 1'b1;
                        mem_w      = cpu_we;
                        mem_addr   = cpu_addr;
                        mem_wdata  = cpu_wdata;
                        mem_dmtype = cpu_dmtype;
                        cpu_stall  = !cpu_we;
                        if (!cpu_we)
                            state_nxt = CPU_RD;
                    end
                end
                CPU_RD: begin
                    cpu_rdata = mem_rdata;
                    state_nxt = IDLE;
                end
                DBG_RD: begin
                    cpu_stall = cpu_req;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter with a cycle-level reference model
//   and a word-addressed memory behind the memory port.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int SM = 8;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_dmtype;
    logic        cpu_stall;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_gnt, dbg_rvalid;
    logic        mem_en, mem_w;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_dmtype;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_dmtype(cpu_dmtype),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dmtype(mem_dmtype), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory behind the port (environment) ----------------
    logic [31:0] ram [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
        ram[4] <= 32'h1234_5678;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_w) ram[mem_addr[9:2]] <= mem_wdata;
            else       mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
        ref_mem[4] = 32'h1234_5678;
    end

    int          ph;       // 0: accepting, 1: CPU load returning, 2: debug load returning
    bit          rv_due;
    logic [31:0] rv_data, held, ld_cpu, ld_dbg;
    bit          dw, cw;
    bit          e_gnt, e_en, e_w, e_stall, e_rvalid;
    logic [31:0] e_addr, e_wd;
    logic [2:0]  e_dm;
`ifdef DMEM_ARB_RR_EN
    bit          ptr_dbg;
`else
    int          starve;
`endif

    initial begin
        ph = 0; rv_due = 1'b0; held = '0; rv_data = '0; ld_cpu = '0; ld_dbg = '0;
`ifdef DMEM_ARB_RR_EN
        ptr_dbg = 1'b0;
`else
        starve = 0;
`endif
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_rst_stall",  32'(cpu_stall),  32'd0);
            chk("m_rst_gnt",    32'(dbg_gnt),    32'd0);
            chk("m_rst_rvalid", 32'(dbg_rvalid), 32'd0);
            chk("m_rst_rdata",  dbg_rdata,       32'd0);
            chk("m_rst_cpurd",  cpu_rdata,       32'd0);
            chk("m_rst_en",     32'(mem_en),     32'd0);
            chk("m_rst_w",      32'(mem_w),      32'd0);
            chk("m_rst_addr",   mem_addr,        32'd0);
            chk("m_rst_wdata",  mem_wdata,       32'd0);
            chk("m_rst_dm",     32'(mem_dmtype), 32'd0);
            ph = 0; rv_due = 1'b0; held = '0;
`ifdef DMEM_ARB_RR_EN
            ptr_dbg = 1'b0;
`else
            starve = 0;
`endif
        end else begin
            e_rvalid = rv_due;
            if (rv_due) held = rv_data;
            rv_due = 1'b0;
            e_gnt = 0; e_en = 0; e_w = 0; e_stall = 0;
            e_addr = '0; e_wd = '0; e_dm = '0;
            if (ph == 1) begin
                chk("m_cpu_rdata", cpu_rdata, ld_cpu);
                ph = 0;
            end else if (ph == 2) begin
                e_stall = cpu_req;
                rv_due  = 1'b1;
                rv_data = ld_dbg;
                ph = 0;
            end else begin
`ifdef DMEM_ARB_RR_EN
                dw = dbg_req && (!cpu_req || ptr_dbg);
                if (cpu_req && dbg_req) ptr_dbg = !dw;
`else
                dw = dbg_req && (!cpu_req || starve >= SM);
`endif
                cw = cpu_req && !dw;
                if (cw) begin
                    e_en = 1; e_w = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
                    e_dm = cpu_dmtype; e_stall = !cpu_we;
                    if (cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
                    else begin ld_cpu = ref_mem[cpu_addr[9:2]]; ph = 1; end
                end else if (dw) begin
                    e_gnt = 1; e_en = 1; e_w = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata;
                    e_stall = cpu_req;
                    if (dbg_we) ref_mem[dbg_addr[9:2]] = dbg_wdata;
                    else begin ld_dbg = ref_mem[dbg_addr[9:2]]; ph = 2; end
                end
            end
`ifndef DMEM_ARB_RR_EN
            if (e_gnt) starve = 0;
            else if (dbg_req && starve < SM) starve++;
`endif
            chk("m_stall",  32'(cpu_stall),  32'(e_stall));
            chk("m_gnt",    32'(dbg_gnt),    32'(e_gnt));
            chk("m_rvalid", 32'(dbg_rvalid), 32'(e_rvalid));
            chk("m_rdata",  dbg_rdata,       held);
            chk("m_en",     32'(mem_en),     32'(e_en));
            chk("m_w",      32'(mem_w),      32'(e_w));
            if (e_en) begin
                chk("m_addr",  mem_addr,        e_addr);
                chk("m_wdata", mem_wdata,       e_wd);
                chk("m_dm",    32'(mem_dmtype), 32'(e_dm));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask
    task automatic sample();
        @(negedge clk);
    endtask
    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_dmtype = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    logic [3:0] vec [12];
    logic [3:0] v;

    initial begin
        idle_inputs();
        rst = 1'b1;
        #1 rst = 1'b0;
        sample();
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_stall",  32'(cpu_stall), 32'd0);
        chk("reset_rdata",  dbg_rdata, 32'd0);
        step(); step();
        rst = 1'b1;

        // CPU load, uncontended
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_dmtype = 3'b010;
        sample();
        chk("load_stall_grant", 32'(cpu_stall), 32'd1);
        chk("load_mem_en",      32'(mem_en), 32'd1);
        chk("load_dmtype",      32'(mem_dmtype), 32'd2);
        chk("load_addr",        mem_addr, 32'h10);
        step();
        sample();
        chk("load_stall_data",  32'(cpu_stall), 32'd0);
        chk("load_rdata",       cpu_rdata, 32'h1234_5678);
        step();
        cpu_req = 0;

        // Debug write then read of 0x40
        step();
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'hDEAD_BEEF;
        sample();
        chk("dbgw_gnt", 32'(dbg_gnt), 32'd1);
        chk("dbgw_w",   32'(mem_w), 32'd1);
        step();
        dbg_we = 0;
        sample();
        chk("dbgr_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 0;
        sample();
        chk("dbgr_rvalid_early", 32'(dbg_rvalid), 32'd0);
        step();
        sample();
        chk("dbgr_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("dbgr_rdata",  dbg_rdata, 32'hDEAD_BEEF);
        step();
        sample();
        chk("dbgr_rvalid_pulse", 32'(dbg_rvalid), 32'd0);
        chk("dbgr_rdata_hold",   dbg_rdata, 32'hDEAD_BEEF);

`ifndef DMEM_ARB_RR_EN
        // Starvation override: CPU stores every cycle, debug waits
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'h0000_0001;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'h55AA_55AA;
        for (int i = 1; i <= 9; i++) begin
            sample();
            chk($sformatf("starve_gnt_c%0d", i),   32'(dbg_gnt),   32'(i == 9));
            chk($sformatf("starve_stall_c%0d", i), 32'(cpu_stall), 32'(i == 9));
            step();
            cpu_addr  = (i % 2 == 1) ? 32'h104 : 32'h100;
            cpu_wdata = 32'(i + 1);
            if (i == 9) dbg_req = 0;
        end
        step();
        cpu_req = 0;
`endif

        // CPU request during a debug read data phase, then withdrawn
        step();
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
        sample();
        chk("inflight_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_dmtype = 3'b000;
        sample();
        chk("inflight_stall", 32'(cpu_stall), 32'd1);
        chk("inflight_no_en", 32'(mem_en), 32'd0);
        step();
        cpu_req = 0;
        sample();
        chk("withdrawn_stall", 32'(cpu_stall), 32'd0);
        chk("withdrawn_no_en", 32'(mem_en), 32'd0);
        chk("inflight_rdata",  dbg_rdata, 32'hDEAD_BEEF);

        // Reset asserted during a debug read data phase
        step();
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
        sample();
        chk("rstrd_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104; cpu_wdata = 32'hFFFF_FFFF; cpu_dmtype = 3'b111;
        rst = 1'b0;
        #1;
        chk("rstrd_stall",  32'(cpu_stall), 32'd0);
        chk("rstrd_gnt0",   32'(dbg_gnt), 32'd0);
        chk("rstrd_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rstrd_rdata",  dbg_rdata, 32'd0);
        chk("rstrd_cpurd",  cpu_rdata, 32'd0);
        chk("rstrd_en",     32'(mem_en), 32'd0);
        chk("rstrd_w",      32'(mem_w), 32'd0);
        chk("rstrd_addr",   mem_addr, 32'd0);
        chk("rstrd_wdata",  mem_wdata, 32'd0);
        chk("rstrd_dm",     32'(mem_dmtype), 32'd0);
        step(); step();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("rstrd_no_rvalid_%0d", i), 32'(dbg_rvalid), 32'd0);
            step();
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_dmtype = 3'b000;
        sample();
        chk("postrst_stall", 32'(cpu_stall), 32'd1);
        step();
        sample();
        chk("postrst_stall2", 32'(cpu_stall), 32'd0);
        chk("postrst_rdata",  cpu_rdata, 32'hDEAD_BEEF);
        step();
        cpu_req = 0;

`ifdef DMEM_ARB_RR_EN
        // Round-robin with both sides writing continuously
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300; cpu_wdata = 32'h0C0C_0C0C;
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'h380; dbg_wdata = 32'h0D0D_0D0D;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("rr_gnt_%0d", i),  32'(dbg_gnt), 32'(i % 2));
            chk($sformatf("rr_addr_%0d", i), mem_addr, (i % 2 == 1) ? 32'h380 : 32'h300);
            step();
        end
        idle_inputs();
`endif

        // Mixed request patterns: {cpu_req, cpu_we, dbg_req, dbg_we}
        vec = '{4'b1010, 4'b1010, 4'b1111, 4'b1011, 4'b0010, 4'b1000,
                4'b1110, 4'b0011, 4'b1100, 4'b1010, 4'b0000, 4'b1110};
        for (int i = 0; i < 12; i++) begin
            step();
            v = vec[i];
            cpu_req = v[3]; cpu_we = v[2]; cpu_addr = 32'h200 + 32'(i * 4);
            cpu_wdata = 32'hC000_0000 | 32'(i); cpu_dmtype = 3'(i);
            dbg_req = v[1]; dbg_we = v[0]; dbg_addr = 32'h200 + 32'(((i + 1) % 12) * 4);
            dbg_wdata = 32'hD000_0000 | 32'(i);
        end
        step();
        idle_inputs();
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
